axi_read_responder: RTL

//  AXI4 read-channel slave (AR/R) backed by an internal word memory. It is the responder end of the
//  CPU fetch master's AR/R bus: it accepts one burst, returns arlen+1 beats, then accepts the next.

---
 rtl/axi_read_responder_if.sv | 30 +++
 rtl/axi_read_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/axi_read_responder_if.sv
// AR/R read-channel bundle between a fetch master and the read responder.
interface axi_read_responder_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]   s_arid;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic [7:0]            s_arlen;
  logic [2:0]            s_arsize;
  logic [1:0]            s_arburst;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [ID_WIDTH-1:0]   s_rid;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rlast;
  logic                  s_rvalid;
  logic                  s_rready;

  modport slave (
    input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
    output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid
  );

  modport master (
    output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
    input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid
  );
endinterface

// File: rtl/axi_read_responder.sv
// AXI4 read responder over an internal word memory; one burst outstanding at a time.
// Define RD_ERR_RESP_EN to return SLVERR with zero data for beats outside the memory window.
//   state    | meaning
//   ST_IDLE  | arready high, waiting for an AR handshake
//   ST_BURST | returning beats; arvalid ignored until the last beat completes
module axi_read_responder #(
  parameter int                    ID_WIDTH   = 13,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter string                 INIT_FILE  = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  axi_read_responder_if.slave  bus
);
  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  state_t                state_q,   state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q,  rvalid_d;
  logic                  rlast_q,   rlast_d;
  logic [ID_WIDTH-1:0]   rid_q,     rid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [7:0]            len_q,     len_d;
  logic [2:0]            size_q,    size_d;
  logic [1:0]            burst_q,   burst_d;
  logic [7:0]            cnt_q,     cnt_d;

  logic                  ar_hs;
  logic                  wrap_ok;
  logic [ADDR_WIDTH-1:0] step, container, addr_incr, addr_next;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_off;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;

  always_comb begin
    ar_hs     = (state_q == ST_IDLE) && bus.s_arvalid && arready_q;
    step      = ADDR_WIDTH'(1) << ((size_q > 3'd3) ? 3'd3 : size_q);
    container = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) * step;
    wrap_ok   = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
    addr_incr = addr_q + step;
    // WRAP keeps the container base bits and lets only the low offset roll over.
    if (burst_q == 2'b00)
      addr_next = addr_q;
    else if (burst_q == 2'b10 && wrap_ok)
      addr_next = (addr_q & ~(container - ADDR_WIDTH'(1))) |
                  (addr_incr & (container - ADDR_WIDTH'(1)));
    else
      addr_next = addr_incr;

    rd_addr = ar_hs ? bus.s_araddr : addr_next;
    rd_off  = rd_addr - BASE_ADDR;
    rd_idx  = IDX_W'(rd_off >> 3);
`ifdef RD_ERR_RESP_EN
    if (rd_off >= (ADDR_WIDTH'(MEM_WORDS) << 3)) begin
      rd_data = '0;
      rd_resp = 2'b10;
    end else begin
      rd_data = mem[rd_idx];
      rd_resp = 2'b00;
    end
`else
    rd_data = mem[rd_idx];
    rd_resp = 2'b00;
`endif
  end

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          state_d   = ST_BURST;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = (bus.s_arlen == 8'd0);
          rid_d     = bus.s_arid;
          rdata_d   = rd_data;
          rresp_d   = rd_resp;
          addr_d    = bus.s_araddr;
          len_d     = bus.s_arlen;
          size_d    = bus.s_arsize;
          burst_d   = bus.s_arburst;
          cnt_d     = 8'd0;
        end
      end
      ST_BURST: begin
        if (rvalid_q && bus.s_rready) begin
          if (rlast_q) begin
            state_d   = ST_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            addr_d  = addr_next;
            cnt_d   = cnt_q + 8'd1;
            rdata_d = rd_data;
            rresp_d = rd_resp;
            rlast_d = ((cnt_q + 8'd1) == len_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.s_arready = arready_q;
  assign bus.s_rvalid  = rvalid_q;
  assign bus.s_rlast   = rlast_q;
  assign bus.s_rid     = rid_q;
  assign bus.s_rdata   = rdata_q;
  assign bus.s_rresp   = rresp_q;
endmodule
